layer_mux_ctrl: RTL and testbench



---
 rtl/layer_mux_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_layer_mux_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mux_ctrl.sv
// Programmable-priority layer compositor: 2-stage pixel pipeline, collision flags and a
// frame-synchronised, double-buffered priority order. Optional LAYER_MUX_COLL_CNT_EN adds coll_count.
module layer_mux_ctrl #(
   parameter int unsigned      NUM_LAYERS  = 4,
   parameter int unsigned      PIX_W       = 8,
   parameter logic [PIX_W-1:0] TRANSPARENT = 8'h00,
   parameter logic [PIX_W-1:0] BG_COLOR    = 8'hFF,
   localparam int unsigned     IW          = $clog2(NUM_LAYERS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        startOfFrame,
   input  logic                        pix_valid,
   input  logic [NUM_LAYERS-1:0]       layer_req,
   input  logic [NUM_LAYERS*PIX_W-1:0] layer_rgb,
   input  logic                        cfg_valid,
   input  logic [NUM_LAYERS*IW-1:0]    cfg_order,
   output logic                        cfg_ready,
   output logic                        cfg_pending,
   output logic                        cfg_err,
   output logic [PIX_W-1:0]            rgb_out,
   output logic                        out_valid,
   output logic                        collision,
   output logic [NUM_LAYERS-1:0]       coll_mask,
   output logic [NUM_LAYERS-1:0]       coll_frame_mask
`ifdef LAYER_MUX_COLL_CNT_EN
   ,
   output logic [15:0]                 coll_count
`endif
);

   typedef enum logic [0:0] {StIdle, StPending} cfg_state_e;

   function automatic logic [NUM_LAYERS*IW-1:0] identity_order();
      logic [NUM_LAYERS*IW-1:0] o;
      o = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         o[k*IW +: IW] = IW'(k);
      end
      return o;
   endfunction

   localparam logic [NUM_LAYERS*IW-1:0] IdentityOrder = identity_order();

   // S1 registers
   logic [NUM_LAYERS-1:0]       s1_opaque_q, s1_opaque_d;
   logic [NUM_LAYERS*PIX_W-1:0] s1_rgb_q;
   logic                        s1_valid_q;

   // S2 registers
   logic [PIX_W-1:0]      rgb_q, rgb_d;
   logic                  out_valid_q;
   logic                  collision_q;
   logic [NUM_LAYERS-1:0] coll_mask_q, coll_mask_d;
   logic [NUM_LAYERS-1:0] frame_mask_q, frame_mask_d;

   // Configuration registers
   cfg_state_e               state_q, state_d;
   logic [NUM_LAYERS*IW-1:0] active_q, active_d;
   logic [NUM_LAYERS*IW-1:0] shadow_q, shadow_d;
   logic                     err_q, err_d;

   logic [PIX_W-1:0]      win_rgb;
   logic                  win_found;
   logic [IW-1:0]         slot_idx;
   logic                  multi_opaque;
   logic                  coll_det;
   logic [NUM_LAYERS-1:0] seen;
   logic [IW-1:0]         cfg_idx;
   logic                  cfg_legal;

   always_comb begin
      s1_opaque_d = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         s1_opaque_d[i] = layer_req[i] && (layer_rgb[i*PIX_W +: PIX_W] != TRANSPARENT);
      end
   end

   // Walk the active order from slot 0; the first opaque layer wins.
   always_comb begin
      win_rgb   = BG_COLOR;
      win_found = 1'b0;
      slot_idx  = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         slot_idx = active_q[k*IW +: IW];
         if (!win_found && s1_opaque_q[slot_idx]) begin
            win_rgb   = s1_rgb_q[slot_idx*PIX_W +: PIX_W];
            win_found = 1'b1;
         end
      end
   end

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign multi_opaque = |(s1_opaque_q & (s1_opaque_q - NUM_LAYERS'(1)));
   assign coll_det     = s1_valid_q && multi_opaque;

   always_comb begin
      rgb_d        = s1_valid_q ? win_rgb : rgb_q;
      coll_mask_d  = coll_det ? s1_opaque_q : coll_mask_q;
      frame_mask_d = (startOfFrame ? '0 : frame_mask_q) | (coll_det ? s1_opaque_q : '0);
   end

   always_comb begin
      seen      = '0;
      cfg_legal = 1'b1;
      cfg_idx   = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         cfg_idx = cfg_order[k*IW +: IW];
         if (32'(cfg_idx) >= NUM_LAYERS) begin
            cfg_legal = 1'b0;
         end else if (seen[cfg_idx]) begin
            cfg_legal = 1'b0;
         end else begin
            seen[cfg_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      shadow_d    = shadow_q;
      err_d       = err_q;
      cfg_ready   = 1'b0;
      cfg_pending = 1'b0;
      case (state_q)
         StIdle: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               if (cfg_legal) begin
                  shadow_d = cfg_order;
                  state_d  = StPending;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StPending: begin
            cfg_pending = 1'b1;
            if (startOfFrame) begin
               active_d = shadow_q;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         active_q <= IdentityOrder;
         shadow_q <= IdentityOrder;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         shadow_q <= shadow_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_opaque_q  <= '0;
         s1_rgb_q     <= '0;
         s1_valid_q   <= 1'b0;
         rgb_q        <= TRANSPARENT;
         out_valid_q  <= 1'b0;
         collision_q  <= 1'b0;
         coll_mask_q  <= '0;
         frame_mask_q <= '0;
      end else begin
         s1_opaque_q  <= s1_opaque_d;
         s1_rgb_q     <= layer_rgb;
         s1_valid_q   <= pix_valid;
         rgb_q        <= rgb_d;
         out_valid_q  <= s1_valid_q;
         collision_q  <= coll_det;
         coll_mask_q  <= coll_mask_d;
         frame_mask_q <= frame_mask_d;
      end
   end

`ifdef LAYER_MUX_COLL_CNT_EN
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] count_q, count_d;
   logic [15:0] cnt_inc;

   always_comb begin
      cnt_inc = (coll_det && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
      cnt_d   = cnt_inc;
      count_d = count_q;
      if (startOfFrame) begin
         count_d = cnt_inc;
         cnt_d   = {15'd0, coll_det};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         count_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         count_q <= count_d;
      end
   end

   assign coll_count = count_q;
`endif

   assign rgb_out         = rgb_q;
   assign out_valid       = out_valid_q;
   assign collision       = collision_q;
   assign coll_mask       = coll_mask_q;
   assign coll_frame_mask = frame_mask_q;
   assign cfg_err         = err_q;

endmodule

// File: tb/tb_layer_mux_ctrl.sv
// Scoreboard bench for layer_mux_ctrl: directed scenarios then random traffic against a
// transaction-level reference model.
module tb_layer_mux_ctrl;

   localparam int NL = 4;
   localparam int PW = 8;
   localparam int IW = 2;
   localparam logic [PW-1:0] TRANSP = 8'h00;
   localparam logic [PW-1:0] BG     = 8'hFF;

   logic             clk = 1'b0;
   logic             reset, startOfFrame, pix_valid, cfg_valid;
   logic [NL-1:0]    layer_req;
   logic [NL*PW-1:0] layer_rgb;
   logic [NL*IW-1:0] cfg_order;
   logic             cfg_ready, cfg_pending, cfg_err, out_valid, collision;
   logic [PW-1:0]    rgb_out;
   logic [NL-1:0]    coll_mask, coll_frame_mask;
`ifdef LAYER_MUX_COLL_CNT_EN
   logic [15:0]      coll_count;
`endif

   layer_mux_ctrl #(
      .NUM_LAYERS (NL),
      .PIX_W      (PW),
      .TRANSPARENT(TRANSP),
      .BG_COLOR   (BG)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .pix_valid      (pix_valid),
      .layer_req      (layer_req),
      .layer_rgb      (layer_rgb),
      .cfg_valid      (cfg_valid),
      .cfg_order      (cfg_order),
      .cfg_ready      (cfg_ready),
      .cfg_pending    (cfg_pending),
      .cfg_err        (cfg_err),
      .rgb_out        (rgb_out),
      .out_valid      (out_valid),
      .collision      (collision),
      .coll_mask      (coll_mask),
      .coll_frame_mask(coll_frame_mask)
`ifdef LAYER_MUX_COLL_CNT_EN
      ,
      .coll_count     (coll_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [PW-1:0] rgb;
      logic          coll;
      logic [NL-1:0] mask;
   } pix_t;

   typedef struct packed {
      logic          ov;
      logic [PW-1:0] rgb;
      logic [NL-1:0] mask;
      logic [NL-1:0] fm;
      logic          rdy;
      logic          pend;
      logic          err;
      logic [15:0]   cnt;
   } stat_t;

   pix_t  pixq[$];
   stat_t statq[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state, describing the block just after the edge being modelled
   int            m_order[NL];
   int            m_shadow[NL];
   bit            m_pend, m_err;
   logic [NL-1:0] m_fm, m_mask;
   logic [PW-1:0] m_rgb;
   int            m_cnt, m_ccount;
   bit            m_ov;
   bit            prev_v;
   pix_t          prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic pix_t ref_pixel(input logic [NL-1:0] req, input logic [NL*PW-1:0] rgbv);
      pix_t          r;
      int            n;
      logic [PW-1:0] c[NL];
      r.mask = '0;
      n      = 0;
      for (int i = 0; i < NL; i++) begin
         c[i] = rgbv[i*PW +: PW];
         if (req[i] && c[i] != TRANSP) begin
            r.mask[i] = 1'b1;
            n++;
         end
      end
      r.coll = (n >= 2);
      r.rgb  = BG;
      for (int k = NL - 1; k >= 0; k--) begin
         if (r.mask[m_order[k]]) r.rgb = c[m_order[k]];
      end
      return r;
   endfunction

   function automatic bit ref_legal(input logic [NL*IW-1:0] o);
      int hits[NL];
      int v;
      for (int i = 0; i < NL; i++) hits[i] = 0;
      for (int k = 0; k < NL; k++) begin
         v = int'(o[k*IW +: IW]);
         if (v >= NL) return 1'b0;
         hits[v]++;
      end
      for (int i = 0; i < NL; i++) if (hits[i] != 1) return 1'b0;
      return 1'b1;
   endfunction

   // Advance the model over the edge that will sample the inputs currently driven.
   task automatic step();
      stat_t s;
      pix_t  p;
      bit    coll_now;
      int    nxt;
      if (reset) begin
         if (prev_v) void'(pixq.pop_back());
         for (int k = 0; k < NL; k++) m_order[k] = k;
         m_pend = 0; m_err = 0; m_fm = '0; m_mask = '0; m_rgb = TRANSP;
         m_cnt = 0; m_ccount = 0; m_ov = 0; prev_v = 0;
      end else begin
         m_ov     = prev_v;
         coll_now = prev_v && prev.coll;
         if (prev_v) m_rgb = prev.rgb;
         if (coll_now) m_mask = prev.mask;
         nxt = m_cnt + (coll_now ? 1 : 0);
         if (nxt > 65535) nxt = 65535;
         if (startOfFrame) begin
            m_ccount = nxt;
            m_cnt    = coll_now ? 1 : 0;
            m_fm     = '0;
         end else begin
            m_cnt = nxt;
         end
         if (coll_now) m_fm = m_fm | prev.mask;
         if (m_pend) begin
            if (startOfFrame) begin
               m_order = m_shadow;
               m_pend  = 0;
            end
         end else if (cfg_valid) begin
            if (ref_legal(cfg_order)) begin
               for (int k = 0; k < NL; k++) m_shadow[k] = int'(cfg_order[k*IW +: IW]);
               m_pend = 1;
            end else begin
               m_err = 1;
            end
         end
         prev_v = pix_valid;
         if (pix_valid) begin
            p    = ref_pixel(layer_req, layer_rgb);
            prev = p;
            pixq.push_back(p);
         end
      end
      s.ov   = m_ov;
      s.rgb  = m_rgb;
      s.mask = m_mask;
      s.fm   = m_fm;
      s.rdy  = !m_pend;
      s.pend = m_pend;
      s.err  = m_err;
      s.cnt  = 16'(m_ccount);
      statq.push_back(s);
   endtask

   task automatic cyc(input logic rst, input logic sof, input logic pv, input logic [NL-1:0] req,
                      input logic [NL*PW-1:0] rgbv, input logic cv, input logic [NL*IW-1:0] co);
      reset        = rst;
      startOfFrame = sof;
      pix_valid    = pv;
      layer_req    = req;
      layer_rgb    = rgbv;
      cfg_valid    = cv;
      cfg_order    = co;
      step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   function automatic logic [PW-1:0] rand_pix();
      if ($urandom_range(0, 3) == 0) return TRANSP;
      return PW'($urandom);
   endfunction

   function automatic logic [NL*IW-1:0] rand_order();
      int                p[NL];
      int                j, t;
      logic [NL*IW-1:0] o;
      if ($urandom_range(0, 5) == 0) return (NL*IW)'($urandom);
      for (int i = 0; i < NL; i++) p[i] = i;
      for (int i = NL - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = p[i]; p[i] = p[j]; p[j] = t;
      end
      for (int k = 0; k < NL; k++) o[k*IW +: IW] = IW'(p[k]);
      return o;
   endfunction

   // Monitor: one status entry per clock, one pixel entry per valid output.
   initial begin
      stat_t s;
      pix_t  p;
      forever begin
         @(negedge clk);
         if (statq.size() == 0) begin
            chk("status_queue_nonempty", 32'(statq.size()), 32'd1);
         end else begin
            s = statq.pop_front();
            chk("out_valid", 32'(out_valid), 32'(s.ov));
            if (s.ov) begin
               if (pixq.size() == 0) begin
                  chk("pixel_queue_nonempty", 32'(pixq.size()), 32'd1);
               end else begin
                  p = pixq.pop_front();
                  chk("rgb_out", 32'(rgb_out), 32'(p.rgb));
                  chk("collision", 32'(collision), 32'(p.coll));
               end
            end else begin
               chk("rgb_out_hold", 32'(rgb_out), 32'(s.rgb));
               chk("collision_idle", 32'(collision), 32'd0);
            end
            chk("coll_mask", 32'(coll_mask), 32'(s.mask));
            chk("coll_frame_mask", 32'(coll_frame_mask), 32'(s.fm));
            chk("cfg_ready", 32'(cfg_ready), 32'(s.rdy));
            chk("cfg_pending", 32'(cfg_pending), 32'(s.pend));
            chk("cfg_err", 32'(cfg_err), 32'(s.err));
`ifdef LAYER_MUX_COLL_CNT_EN
            chk("coll_count", 32'(coll_count), 32'(s.cnt));
`endif
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NL*PW-1:0] c1, c3;
      logic [NL-1:0]    rq;
      logic             pv, sof, cv, rst;
      c1 = {8'h00, 8'hE0, 8'h1C, 8'h00};
      c3 = {8'h03, 8'hE0, 8'h1C, 8'h00};
      prev_v = 0;
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      idle(1);
      // layers 1 and 2 collide, layer 1 wins under identity order
      cyc(1'b0, 1'b0, 1'b1, 4'b0110, c1, 1'b0, '0);
      idle(3);
      // only layer 0 requests, with a transparent colour
      cyc(1'b0, 1'b0, 1'b1, 4'b0001, {8'h55, 8'h66, 8'h77, 8'h00}, 1'b0, '0);
      idle(3);
      // reorder to slot 0 = layer 3, offered mid-frame
      cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
      idle(2);
      cyc(1'b0, 1'b0, 1'b1, 4'b1110, c3, 1'b1, {2'd0, 2'd1, 2'd2, 2'd3});
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 4'b1110, c3, 1'b0, '0);
      cyc(1'b0, 1'b1, 1'b1, 4'b1110, c3, 1'b0, '0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 4'b1110, c3, 1'b0, '0);
      idle(2);
      // duplicate index, then legal order, then an ignored offer while pending
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, {2'd1, 2'd1, 2'd2, 2'd3});
      cyc(1'b0, 1'b0, 1'b1, 4'b1110, c3, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, {2'd3, 2'd2, 2'd1, 2'd0});
      cyc(1'b0, 1'b0, 1'b1, 4'b1110, c3, 1'b1, {2'd2, 2'd3, 2'd0, 2'd1});
      cyc(1'b0, 1'b1, 1'b1, 4'b1110, c3, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b1, 4'b1110, c3, 1'b0, '0);
      idle(2);
      // reset while pending with pixels in flight
      cyc(1'b0, 1'b0, 1'b1, 4'b1111, c3, 1'b1, {2'd0, 2'd1, 2'd2, 2'd3});
      cyc(1'b0, 1'b0, 1'b1, 4'b1011, c3, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b1, 4'b1111, c3, 1'b0, '0);
      idle(3);
      cyc(1'b0, 1'b1, 1'b1, 4'b1110, c3, 1'b0, '0);
      idle(3);
      // five collisions, the last coincident with the closing frame boundary
      cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 4'b0011, {8'h00, 8'h00, 8'h40, 8'h21}, 1'b0, '0);
         idle(1);
      end
      cyc(1'b0, 1'b0, 1'b1, 4'b1100, {8'h12, 8'h34, 8'h00, 8'h00}, 1'b0, '0);
      cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
      idle(4);
      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rq  = NL'($urandom);
         pv  = ($urandom_range(0, 4) != 0);
         sof = ($urandom_range(0, 24) == 0);
         cv  = ($urandom_range(0, 11) == 0);
         rst = ($urandom_range(0, 499) == 0);
         cyc(rst, sof, pv, rq, {rand_pix(), rand_pix(), rand_pix(), rand_pix()}, cv, rand_order());
      end
      idle(4);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
